keypad_scanner: RTL and testbench

- Drives the columns of a 4x4 matrix keypad and reads its rows.
- Locates a pressed key and presents it as a one-hot {row,col} code with a level-valid flag.
- Sits directly upstream of the keypad debouncer, which consumes key_code and key_pressed.
- Holds the scan on the active column while a key is held, so the code is stable for the debouncer's whole interval.

---
 rtl/keypad_scanner.sv | 77 +++++++
 tb/tb_keypad_scanner.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix column scanner that locks onto a held key and reports it one-hot.
module keypad_scanner #(
  parameter int SCAN_DIV    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       new_key
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  typedef enum logic [1:0] {SCAN = 2'd0, HOLD = 2'd1} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0][3:0] sync;
  logic [3:0] rows_act, pri_row;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] col_idx, col_n;
  logic [7:0] code_n;
  logic new_n, sample;
  assign rows_act = ~sync[SYNC_STAGES-1];
  assign sample = cnt == CW'(SCAN_DIV - 1);
  assign pri_row = rows_act[0] ? 4'b0001 : rows_act[1] ? 4'b0010 :
                   rows_act[2] ? 4'b0100 : rows_act[3] ? 4'b1000 : 4'b0000;
  assign key_pressed = state == HOLD;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    col_n = col_idx;
    code_n = key_code;
    new_n = 1'b0;
    case (state)
      SCAN: begin
        cnt_n = sample ? '0 : cnt + CW'(1);
        if (sample && |rows_act) begin
          state_n = HOLD;
          code_n = {pri_row, 4'b0001 << col_idx};
          new_n = 1'b1;
        end else if (sample) begin
          col_n = col_idx + 2'd1;
        end
      end
      // only the captured row keeps the lock; everything else is ignored
      HOLD: if (~|(rows_act & key_code[7:4])) begin
        state_n = SCAN;
        col_n = col_idx + 2'd1;
        cnt_n = '0;
      end
      default: begin
        state_n = SCAN;
        col_n = 2'd0;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SCAN;
      cnt <= '0;
      col_idx <= 2'd0;
      cols_n <= 4'b1110;
      key_code <= 8'h00;
      new_key <= 1'b0;
      sync <= '1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      col_idx <= col_n;
      cols_n <= ~(4'b0001 << col_n);
      key_code <= code_n;
      new_key <= new_n;
      sync <= {sync[SYNC_STAGES-2:0], rows_n};
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad matrix model driving the scanner, table vectors plus directed corner sequences.
module tb_keypad_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] rows_n, cols_n;
  logic [7:0] key_code;
  logic key_pressed, new_key;
  logic [15:0] keys = '0;
  int n_cmp = 0;
  int n_err = 0;
  keypad_scanner #(.SCAN_DIV(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rows_n(rows_n), .cols_n(cols_n),
    .key_code(key_code), .key_pressed(key_pressed), .new_key(new_key)
  );
  always #5 clk = ~clk;
  always_comb begin
    rows_n = '1;
    for (int r = 0; r < 4; r++) rows_n[r] = ~|(keys[r*4 +: 4] & ~cols_n);
  end
  typedef struct {
    string nm;
    logic [15:0] keys;
    logic [7:0] code;
    logic [3:0] hold_cols;
    logic [3:0] rel_cols;
  } vec_t;
  vec_t tv[6];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wait_press();
    int n = 0;
    while (!key_pressed && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("press_seen", {31'd0, key_pressed}, 1);
    check("press_new_key", {31'd0, new_key}, 1);
  endtask
  task automatic release_check(input string nm, input logic [3:0] exp_cols, input logic [7:0] exp_code);
    @(negedge clk);
    check({nm, "_rel1_kp"}, {31'd0, key_pressed}, 1);
    @(negedge clk);
    check({nm, "_rel2_kp"}, {31'd0, key_pressed}, 1);
    @(negedge clk);
    check({nm, "_rel3_kp"}, {31'd0, key_pressed}, 0);
    check({nm, "_rel_cols"}, {28'd0, cols_n}, {28'd0, exp_cols});
    check({nm, "_rel_code"}, {24'd0, key_code}, {24'd0, exp_code});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tv[0] = '{"r2c1", 16'h0200, 8'b0100_0010, 4'b1101, 4'b1011};
    tv[1] = '{"r0c0", 16'h0001, 8'b0001_0001, 4'b1110, 4'b1101};
    tv[2] = '{"r3c3", 16'h8000, 8'b1000_1000, 4'b0111, 4'b1110};
    tv[3] = '{"r1r3c0", 16'h1010, 8'b0010_0001, 4'b1110, 4'b1101};
    tv[4] = '{"all_c2", 16'h4444, 8'b0001_0100, 4'b1011, 4'b0111};
    tv[5] = '{"r2r3c2", 16'h4400, 8'b0100_0100, 4'b1011, 4'b0111};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check("idle_cols", {28'd0, cols_n}, {28'd0, ~(4'b0001 << ((k / 4) % 4))});
      check("idle_kp", {31'd0, key_pressed}, 0);
      check("idle_new", {31'd0, new_key}, 0);
      check("idle_code", {24'd0, key_code}, 0);
      if (k < 19) @(negedge clk);
    end
    keys = 16'h0200;
    @(negedge clk);
    check("lat_col1", {28'd0, cols_n}, 32'hd);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("lat_early_kp", {31'd0, key_pressed}, 0);
    end
    @(negedge clk);
    check("lat_kp", {31'd0, key_pressed}, 1);
    check("lat_new", {31'd0, new_key}, 1);
    check("lat_code", {24'd0, key_code}, 32'h42);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("hold_cols", {28'd0, cols_n}, 32'hd);
      check("hold_kp", {31'd0, key_pressed}, 1);
      check("hold_new", {31'd0, new_key}, 0);
    end
    keys = '0;
    release_check("lat", 4'b1011, 8'h42);
    for (int i = 0; i < 6; i++) begin
      keys = tv[i].keys;
      wait_press();
      check({tv[i].nm, "_code"}, {24'd0, key_code}, {24'd0, tv[i].code});
      check({tv[i].nm, "_cols"}, {28'd0, cols_n}, {28'd0, tv[i].hold_cols});
      @(negedge clk);
      check({tv[i].nm, "_new_off"}, {31'd0, new_key}, 0);
      check({tv[i].nm, "_kp_on"}, {31'd0, key_pressed}, 1);
      keys = '0;
      release_check(tv[i].nm, tv[i].rel_cols, tv[i].code);
    end
    keys = 16'h1010;
    wait_press();
    check("two_code", {24'd0, key_code}, 32'h21);
    keys = 16'h0010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("two_other_rel_kp", {31'd0, key_pressed}, 1);
    end
    keys = '0;
    release_check("two", 4'b1101, 8'h21);
    keys = 16'h0004;
    wait_press();
    check("ign_code", {24'd0, key_code}, 32'h14);
    keys = 16'h1004;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("ign_code_hold", {24'd0, key_code}, 32'h14);
      check("ign_cols", {28'd0, cols_n}, 32'hb);
      check("ign_new", {31'd0, new_key}, 0);
    end
    keys = 16'h1000;
    release_check("ign", 4'b0111, 8'h14);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      check("ign_rescan_cols", {28'd0, cols_n}, k < 4 ? 32'h7 : 32'he);
      check("ign_rescan_kp", {31'd0, key_pressed}, 0);
    end
    @(negedge clk);
    check("ign_r3c0_kp", {31'd0, key_pressed}, 1);
    check("ign_r3c0_new", {31'd0, new_key}, 1);
    check("ign_r3c0_code", {24'd0, key_code}, 32'h81);
    @(negedge clk);
    keys = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_cols", {28'd0, cols_n}, 32'he);
    check("rst_code", {24'd0, key_code}, 0);
    check("rst_kp", {31'd0, key_pressed}, 0);
    check("rst_new", {31'd0, new_key}, 0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      check("rst_cnt_cols", {28'd0, cols_n}, k < 4 ? 32'he : 32'hd);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
